t05_instr_sequencer: RTL and testbench

//  Multi-cycle control FSM that drives the t05 register-file/ALU datapath one instruction at a time.
//  Per instruction it: fetches over a req/ack memory port, latches IR, gives the ALU its operands,

---
 rtl/t05_instr_sequencer.sv | 141 ++++++++++++++
 tb/tb_t05_instr_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t05_instr_sequencer.sv
// Multi-cycle control FSM for the t05 datapath: fetch over a req/ack port, decode,
// execute, optional load/store memory phase, then writeback and PC update.
module t05_instr_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_waddr,
  input  logic        alu_branch,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        alu_source,
  output logic        reg_we,
  output logic [31:0] reg_wdata,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t      state, state_next;
  logic [31:0] load_data;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] jalr_target;
  logic [6:0]  opcode;
  logic        is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui;
  logic        legal;

  assign opcode      = ir[6:0];
  assign is_r        = (opcode == OP_R);
  assign is_i        = (opcode == OP_I);
  assign is_load     = (opcode == OP_LOAD);
  assign is_store    = (opcode == OP_STORE);
  assign is_branch   = (opcode == OP_BRANCH);
  assign is_jal      = (opcode == OP_JAL);
  assign is_jalr     = (opcode == OP_JALR);
  assign is_lui      = (opcode == OP_LUI);
  assign legal       = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr | is_lui;
  assign pc_plus4    = pc + 32'd4;
  assign jalr_target = (rs1_data + imm) & ~32'd1;

  always_comb begin
    pc_next = pc_plus4;
    if (is_jal || (is_branch && alu_branch)) pc_next = pc + imm;
    else if (is_jalr)                        pc_next = jalr_target;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      ir        <= NOP_INSTR;
      load_data <= '0;
    end else begin
      if (state == S_FETCH && mem_ack)            ir        <= mem_rdata;
      if (state == S_MEM && mem_ack && is_load)   load_data <= mem_rdata;
      if (state == S_WRITEBACK)                   pc        <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:      if (en) state_next = S_FETCH;
      S_FETCH:     if (mem_ack) state_next = S_DECODE;
      S_DECODE:    state_next = legal ? S_EXECUTE : S_HALT;
      S_EXECUTE:   state_next = (is_load || is_store) ? S_MEM : S_WRITEBACK;
      S_MEM:       if (mem_ack) state_next = S_WRITEBACK;
      S_WRITEBACK: state_next = en ? S_FETCH : S_IDLE;
      S_HALT:      state_next = S_HALT;
      default:     state_next = S_IDLE;
    endcase
  end

  // Operand select is held from EXECUTE through WRITEBACK so alu_result stays valid
  // for the memory address/data and the writeback value.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    alu_source = 1'b0;
    reg_we     = 1'b0;
    reg_wdata  = '0;
    halted     = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      S_EXECUTE: alu_source = legal && !is_r && !is_branch;
      S_MEM: begin
        alu_source = 1'b1;
        mem_req    = 1'b1;
        if (is_store) begin
          mem_we    = 1'b1;
          mem_addr  = alu_waddr;
          mem_wdata = alu_result;
        end else begin
          mem_addr  = alu_result;
        end
      end
      S_WRITEBACK: begin
        alu_source = !is_r && !is_branch;
        reg_we     = !is_store && !is_branch;
        if (is_load)                reg_wdata = load_data;
        else if (is_jal || is_jalr) reg_wdata = pc_plus4;
        else                        reg_wdata = alu_result;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_t05_instr_sequencer.sv
// Self-checking bench for t05_instr_sequencer: a bench-side memory responder drives the
// handshake; expected register writes are queued per instruction and popped on reg_we.
module tb_t05_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst, en, mem_ack, alu_branch;
  logic [31:0] mem_rdata, alu_result, alu_waddr, imm, rs1_data;
  logic        mem_req, mem_we, alu_source, reg_we, halted;
  logic [31:0] mem_addr, mem_wdata, pc, ir, reg_wdata;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] wr_q[$];
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  t05_instr_sequencer #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .en(en), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .alu_result(alu_result), .alu_waddr(alu_waddr), .alu_branch(alu_branch),
    .imm(imm), .rs1_data(rs1_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pc(pc), .ir(ir),
    .alu_source(alu_source), .reg_we(reg_we), .reg_wdata(reg_wdata), .halted(halted)
  );

  // Scoreboard consumer: every reg_we pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && reg_we) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL reg_write_unexpected: got reg_wdata=%h, required no write", reg_wdata);
      end else begin
        logic [31:0] exp_wd;
        exp_wd = wr_q.pop_front();
        if (reg_wdata !== exp_wd) begin
          errors++;
          $display("FAIL reg_wdata: got %h, required %h", reg_wdata, exp_wd);
        end
      end
    end
  end

  // Runs one instruction starting at a negedge; returns at the negedge where pc has moved.
  task automatic run_instr(input logic [31:0] instr, input logic [31:0] ar, input logic [31:0] aw,
                           input logic br, input logic [31:0] im, input logic [31:0] rs1,
                           input int unsigned fwait, input int unsigned mwait,
                           input logic [31:0] ldata, input logic en_after);
    logic [6:0]  op;
    logic        is_ld, is_st, is_mem, exp_we, exp_src;
    logic [31:0] old_pc, exp_pc, exp_wd, exp_addr;
    int unsigned cyc, waited, since, n_we, exp_cyc;
    bit          started, fetched, mem_done, done;
    op      = instr[6:0];
    is_ld   = (op == 7'b0000011);
    is_st   = (op == 7'b0100011);
    is_mem  = is_ld | is_st;
    exp_we  = !(is_st || op == 7'b1100011);
    exp_src = !(op == 7'b0110011 || op == 7'b1100011);
    old_pc  = model_pc;
    if (is_ld)                                  exp_wd = ldata;
    else if (op == 7'b1101111 || op == 7'b1100111) exp_wd = old_pc + 32'd4;
    else                                        exp_wd = ar;
    if (op == 7'b1101111 || (op == 7'b1100011 && br)) exp_pc = old_pc + im;
    else if (op == 7'b1100111)                  exp_pc = (rs1 + im) & 32'hFFFF_FFFE;
    else                                        exp_pc = old_pc + 32'd4;
    exp_cyc  = 4 + fwait + (is_mem ? 1 + mwait : 0);
    exp_addr = is_st ? aw : ar;
    alu_result = ar; alu_waddr = aw; alu_branch = br; imm = im; rs1_data = rs1; en = 1'b1;
    if (exp_we) wr_q.push_back(exp_wd);
    cyc = 0; waited = 0; since = 0; n_we = 0;
    started = 0; fetched = 0; mem_done = 0; done = 0;
    for (int g = 0; g < 100; g++) begin
      if (started && pc !== old_pc) begin done = 1; break; end
      if (mem_req) started = 1;
      if (started) cyc++;
      if (reg_we) n_we++;
      mem_ack = 1'b0;
      if (mem_req && !fetched) begin
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== old_pc) begin
          errors++;
          $display("FAIL fetch_req: got we=%b addr=%h, required we=0 addr=%h", mem_we, mem_addr, old_pc);
        end
        if (waited == fwait) begin
          mem_ack = 1'b1; mem_rdata = instr; fetched = 1; waited = 0;
        end else waited++;
      end else if (mem_req) begin
        checks++;
        if (mem_we !== is_st || mem_addr !== exp_addr || (is_st && mem_wdata !== ar)) begin
          errors++;
          $display("FAIL mem_req: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                   mem_we, mem_addr, mem_wdata, is_st, exp_addr, ar);
        end
        if (waited == mwait) begin
          mem_ack = 1'b1; mem_rdata = ldata; mem_done = 1;
        end else waited++;
      end
      if (fetched) since++;
      if (since == 2) begin
        checks++;
        if (ir !== instr) begin
          errors++;
          $display("FAIL ir_latch: got %h, required %h", ir, instr);
        end
        en = en_after;
      end
      if (since == 3) begin
        checks++;
        if (alu_source !== exp_src) begin
          errors++;
          $display("FAIL alu_source: got %b, required %b (instr %h)", alu_source, exp_src, instr);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL instr_timeout: got no pc update for %h, required pc=%h", instr, exp_pc);
    end
    checks++;
    if (pc !== exp_pc) begin
      errors++;
      $display("FAIL pc_update: got %h, required %h (instr %h)", pc, exp_pc, instr);
    end
    checks++;
    if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL latency: got %0d cycles, required %0d (instr %h)", cyc, exp_cyc, instr);
    end
    checks++;
    if (n_we != (exp_we ? 1 : 0) || mem_done != is_mem) begin
      errors++;
      $display("FAIL pulses: got reg_we=%0d mem_phase=%0d, required reg_we=%0d mem_phase=%0d",
               n_we, mem_done, exp_we, is_mem);
    end
    model_pc = exp_pc;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mem_ack = 1'b0; mem_rdata = '0; alu_result = '0;
    alu_waddr = '0; alu_branch = 1'b0; imm = '0; rs1_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (pc !== 32'h0 || ir !== 32'h13 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        reg_we !== 1'b0 || halted !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got pc=%h ir=%h req=%b we=%b reg_we=%b halted=%b addr=%h, required 0/13/0/0/0/0/0",
               pc, ir, mem_req, mem_we, reg_we, halted, mem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || pc !== 32'h0) begin
        errors++;
        $display("FAIL idle_hold: got req=%b pc=%h, required req=0 pc=0", mem_req, pc);
      end
    end
    model_pc = 32'h0;
  endtask

  task automatic test_alu_ops();
    run_instr(32'h0050_0093, 32'h5, '0, 1'b0, 32'h5, '0, 0, 0, '0, 1'b1);            // addi
    run_instr(32'h0000_A103, 32'h40, '0, 1'b0, '0, '0, 0, 3, 32'hDEAD_BEEF, 1'b1);   // lw
    run_instr(32'h0020_A023, 32'h1234, 32'h80, 1'b0, '0, '0, 2, 0, '0, 1'b1);        // sw
    run_instr(32'h0020_81B3, 32'h77, '0, 1'b0, '0, '0, 0, 0, '0, 1'b1);              // add
  endtask

  task automatic test_branches();
    run_instr(32'h0000_0063, '0, '0, 1'b1, 32'hFFFF_FFF8, '0, 0, 0, '0, 1'b1);       // 0x10 -> 0x08
    run_instr(32'h0000_006F, '0, '0, 1'b0, 32'h8, '0, 1, 0, '0, 1'b1);               // 0x08 -> 0x10
    run_instr(32'h0000_0063, '0, '0, 1'b0, 32'hFFFF_FFF8, '0, 0, 0, '0, 1'b1);       // 0x10 -> 0x14
  endtask

  task automatic test_jumps();
    run_instr(32'h0000_8067, '0, '0, 1'b0, '0, 32'hFFFF_FFFD, 0, 0, '0, 1'b1);       // -> 0xFFFFFFFC
    run_instr(32'h0000_006F, '0, '0, 1'b0, 32'h8, '0, 0, 0, '0, 1'b1);               // wraps to 0x4
    run_instr(32'h0000_8067, '0, '0, 1'b0, '0, 32'h101, 0, 0, '0, 1'b1);             // -> 0x100
    run_instr(32'h1234_50B7, 32'h1234_5000, '0, 1'b0, '0, '0, 0, 0, '0, 1'b0);       // lui, then stop
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_req !== 1'b0 || pc !== 32'h104) begin
        errors++;
        $display("FAIL en_stop: got req=%b pc=%h, required req=0 pc=00000104", mem_req, pc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_halt();
    bit found;
    found = 0;
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) begin found = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!found || mem_addr !== 32'h104) begin
      errors++;
      $display("FAIL halt_fetch: got found=%0d addr=%h, required found=1 addr=00000104", found, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_early: got halted=%b in decode, required 0", halted);
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (halted !== 1'b1 || mem_req !== 1'b0 || reg_we !== 1'b0) begin
        errors++;
        $display("FAIL halt_sticky: got halted=%b req=%b reg_we=%b, required 1/0/0", halted, mem_req, reg_we);
      end
      mem_ack = i[0];
      @(negedge clk);
    end
    mem_ack = 1'b0; en = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (halted !== 1'b0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL halt_reset: got halted=%b pc=%h, required 0 and 00000000", halted, pc);
    end
    model_pc = 32'h0;
  endtask

  task automatic test_reset_during_store();
    bit found;
    found = 0;
    alu_result = 32'hABCD; alu_waddr = 32'h200; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) begin found = 1; break; end
      @(negedge clk);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0020_A023;
    @(negedge clk);
    mem_ack = 1'b0; en = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (!found || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hABCD) begin
        errors++;
        $display("FAIL store_pending: got req=%b we=%b addr=%h wdata=%h, required 1/1/00000200/0000abcd",
                 mem_req, mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || pc !== 32'h0 || ir !== 32'h13) begin
      errors++;
      $display("FAIL store_reset: got req=%b pc=%h ir=%h, required 0/00000000/00000013", mem_req, pc, ir);
    end
    mem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || reg_we !== 1'b0 || pc !== 32'h0) begin
        errors++;
        $display("FAIL stale_ack: got req=%b reg_we=%b pc=%h, required 0/0/00000000", mem_req, reg_we, pc);
      end
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_alu_ops();
    test_branches();
    test_jumps();
    test_halt();
    test_reset_during_store();
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: got %0d writes outstanding, required 0", wr_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
